// File: rtl/mskaes_job_arbiter_pkg.sv
// Shared types for the masked-AES job arbiter.
// FSM encoding and share-bus width constants.
package mskaes_job_arbiter_pkg;

    localparam int BLK  = 128;
    localparam int KEYW = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DELIVER = 2'd2,
        RSTW    = 2'd3
    } state_e;

endpackage

// File: rtl/mskaes_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NREQ-1 back to 0; returns one-hot grant and its index.
module mskaes_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int c;
        c      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (i == c)) begin
                    any       = 1'b1;
                    onehot[i] = 1'b1;
                    idx       = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mskaes_job_arbiter.sv
// Round-robin arbiter sharing one masked AES core between NREQ requesters.
// Optional watchdog on RUN enabled by MSKAES_ARB_WATCHDOG_EN.
module mskaes_job_arbiter
    import mskaes_job_arbiter_pkg::*;
#(
    parameter int d    = 2,
    parameter int NREQ = 2,
    parameter int IDW  = 3
`ifdef MSKAES_ARB_WATCHDOG_EN
    ,
    parameter int WD_LIMIT = 1023
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_inverse,
    input  logic [NREQ*BLK*d-1:0]  req_sh_plaintext,
    input  logic [NREQ*KEYW*d-1:0] req_sh_key,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [BLK*d-1:0]       rsp_sh_ciphertext,
    output logic                   core_rst,
    output logic                   core_valid_in,
    input  logic                   core_in_ready,
    output logic                   core_inverse,
    output logic [BLK*d-1:0]       core_sh_plaintext,
    output logic [KEYW*d-1:0]      core_sh_key,
    input  logic                   core_cipher_valid,
    output logic                   core_out_ready,
    input  logic [BLK*d-1:0]       core_sh_ciphertext,
`ifdef MSKAES_ARB_WATCHDOG_EN
    output logic                   wd_err,
`endif
    output logic                   busy
);

    localparam int PTW = BLK * d;
    localparam int KW  = KEYW * d;

    state_e         state_q, state_d;
    logic           rstw_q, rstw_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           inv_q, inv_d;
`ifdef MSKAES_ARB_WATCHDOG_EN
    logic [9:0]     wd_cnt_q, wd_cnt_d;
    logic           wd_err_q, wd_err_d;
`endif

    logic [NREQ-1:0] g_oh;
    logic [IDW-1:0]  g_idx;
    logic            g_any;
    logic [NREQ-1:0] own_oh;
    logic [PTW-1:0]  sel_pt;
    logic [KW-1:0]   sel_key;
    logic            sel_inv;

    mskaes_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_q),
        .onehot (g_oh),
        .idx    (g_idx),
        .any    (g_any)
    );

    // One-hot AND-OR mux: unselected requesters contribute all-zero sharings.
    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        sel_inv = 1'b0;
        own_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_oh[i]) begin
                sel_pt  = sel_pt  | req_sh_plaintext[i*PTW +: PTW];
                sel_key = sel_key | req_sh_key[i*KW +: KW];
                sel_inv = sel_inv | req_inverse[i];
            end
            own_oh[i] = (owner_q == IDW'(i));
        end
    end

    always_comb begin
        state_d           = state_q;
        rstw_d            = rstw_q;
        rr_d              = rr_q;
        owner_d           = owner_q;
        inv_d             = inv_q;
`ifdef MSKAES_ARB_WATCHDOG_EN
        wd_cnt_d          = wd_cnt_q;
        wd_err_d          = wd_err_q;
`endif
        req_ready         = '0;
        rsp_valid         = '0;
        rsp_sh_ciphertext = '0;
        core_valid_in     = 1'b0;
        core_out_ready    = 1'b0;
        core_inverse      = inv_q;
        core_sh_plaintext = '0;
        core_sh_key       = '0;
        unique case (state_q)
            RSTW: begin
                if (rstw_q) begin
                    rstw_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rstw_d  = 1'b1;
                end
            end
            IDLE: begin
                if (g_any && core_in_ready) begin
                    core_valid_in     = 1'b1;
                    req_ready         = g_oh;
                    core_sh_plaintext = sel_pt;
                    core_sh_key       = sel_key;
                    core_inverse      = sel_inv;
                    owner_d           = g_idx;
                    inv_d             = sel_inv;
                    state_d           = RUN;
`ifdef MSKAES_ARB_WATCHDOG_EN
                    wd_cnt_d          = '0;
`endif
                end
            end
            RUN: begin
                if (core_cipher_valid) begin
                    state_d = DELIVER;
`ifdef MSKAES_ARB_WATCHDOG_EN
                end else if (wd_cnt_q + 10'd1 == 10'(WD_LIMIT)) begin
                    // Preloading rstw gives a single-cycle core_rst pulse.
                    state_d  = RSTW;
                    rstw_d   = 1'b1;
                    wd_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 10'd1;
`endif
                end
            end
            DELIVER: begin
                rsp_valid      = own_oh & {NREQ{core_cipher_valid}};
                core_out_ready = |(own_oh & rsp_ready);
                if (core_cipher_valid) begin
                    rsp_sh_ciphertext = core_sh_ciphertext;
                end
                if (core_cipher_valid && core_out_ready) begin
                    rr_d    = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RSTW;
            rstw_q   <= 1'b0;
            rr_q     <= '0;
            owner_q  <= '0;
            inv_q    <= 1'b0;
`ifdef MSKAES_ARB_WATCHDOG_EN
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rstw_q   <= rstw_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            inv_q    <= inv_d;
`ifdef MSKAES_ARB_WATCHDOG_EN
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
`endif
        end
    end

    assign core_rst = (state_q == RSTW);
    assign busy     = (state_q != IDLE);
`ifdef MSKAES_ARB_WATCHDOG_EN
    assign wd_err   = wd_err_q;
`endif

endmodule

// File: tb/tb_mskaes_job_arbiter.sv
// Self-checking bench for mskaes_job_arbiter (NREQ=2, d=2).
// Job table plus hand sequences for reset, stall and abort corners.
module tb_mskaes_job_arbiter;

    localparam int D    = 2;
    localparam int NREQ = 2;
    localparam int PTW  = 128 * D;
    localparam int KW   = 256 * D;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_inverse;
    logic [NREQ*PTW-1:0]  req_sh_plaintext;
    logic [NREQ*KW-1:0]   req_sh_key;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [PTW-1:0]       rsp_sh_ciphertext;
    logic                 core_rst;
    logic                 core_valid_in;
    logic                 core_in_ready;
    logic                 core_inverse;
    logic [PTW-1:0]       core_sh_plaintext;
    logic [KW-1:0]        core_sh_key;
    logic                 core_cipher_valid;
    logic                 core_out_ready;
    logic [PTW-1:0]       core_sh_ciphertext;
    logic                 busy;
`ifdef MSKAES_ARB_WATCHDOG_EN
    logic                 wd_err;
`endif

    mskaes_job_arbiter #(
        .d    (D),
        .NREQ (NREQ),
        .IDW  (3)
`ifdef MSKAES_ARB_WATCHDOG_EN
        ,
        .WD_LIMIT (20)
`endif
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_inverse        (req_inverse),
        .req_sh_plaintext   (req_sh_plaintext),
        .req_sh_key         (req_sh_key),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_sh_ciphertext  (rsp_sh_ciphertext),
        .core_rst           (core_rst),
        .core_valid_in      (core_valid_in),
        .core_in_ready      (core_in_ready),
        .core_inverse       (core_inverse),
        .core_sh_plaintext  (core_sh_plaintext),
        .core_sh_key        (core_sh_key),
        .core_cipher_valid  (core_cipher_valid),
        .core_out_ready     (core_out_ready),
        .core_sh_ciphertext (core_sh_ciphertext),
`ifdef MSKAES_ARB_WATCHDOG_EN
        .wd_err             (wd_err),
`endif
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic [1:0] inv;
        int         lat;
        int         stall;
        logic       own;
    } job_t;

    typedef struct {
        logic [1:0]     oh;
        logic [PTW-1:0] ct;
    } sb_t;

    int          checks;
    int          errors;
    sb_t         sb[$];
    logic [PTW-1:0] pt [2];
    logic [KW-1:0]  key[2];
    job_t        jobs[7];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input job_t j);
        logic [1:0]     eoh;
        logic [PTW-1:0] ct;
        sb_t            e;
        eoh = j.own ? 2'b10 : 2'b01;
        for (int w = 0; w < PTW / 32; w++) ct[32*w +: 32] = $urandom();
        req_valid     = j.rv;
        req_inverse   = j.inv;
        core_in_ready = 1'b1;
        rsp_ready     = '0;
        @(negedge clk);
        chk("grant_ready", 512'(req_ready), 512'(eoh));
        chk("grant_vin", 512'(core_valid_in), 512'(1'b1));
        chk("grant_pt", 512'(core_sh_plaintext), 512'(pt[j.own]));
        chk("grant_key", 512'(core_sh_key), key[j.own]);
        chk("grant_inv", 512'(core_inverse), 512'(j.inv[j.own]));
        e.oh = eoh;
        e.ct = ct;
        sb.push_back(e);
        step();
        for (int l = 0; l < j.lat; l++) begin
            @(negedge clk);
            chk("run_ready", 512'(req_ready), 512'(0));
            chk("run_pt_zero", 512'(core_sh_plaintext), 512'(0));
            chk("run_rsp_zero", 512'(rsp_sh_ciphertext), 512'(0));
            chk("run_rspv", 512'(rsp_valid), 512'(0));
            chk("run_inv", 512'(core_inverse), 512'(j.inv[j.own]));
            step();
        end
        core_cipher_valid  = 1'b1;
        core_sh_ciphertext = ct;
        @(negedge clk);
        chk("run_cv_rspv", 512'(rsp_valid), 512'(0));
        step();
        rsp_ready = ~eoh;
        for (int s = 0; s < j.stall; s++) begin
            @(negedge clk);
            chk("stall_rspv", 512'(rsp_valid), 512'(eoh));
            chk("stall_oready", 512'(core_out_ready), 512'(0));
            chk("stall_ready", 512'(req_ready), 512'(0));
            step();
        end
        rsp_ready = eoh;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 512'(1), 512'(0));
        end else begin
            e = sb.pop_front();
            chk("dlv_rspv", 512'(rsp_valid), 512'(e.oh));
            chk("dlv_ct", 512'(rsp_sh_ciphertext), 512'(e.ct));
        end
        chk("dlv_oready", 512'(core_out_ready), 512'(1'b1));
        chk("dlv_ready", 512'(req_ready), 512'(0));
        step();
        core_cipher_valid  = 1'b0;
        core_sh_ciphertext = '0;
        rsp_ready          = '0;
        req_valid          = '0;
        @(negedge clk);
        chk("idle_busy", 512'(busy), 512'(0));
        chk("idle_rspv", 512'(rsp_valid), 512'(0));
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < PTW / 32; w++) pt[i][32*w +: 32] = $urandom();
            for (int w = 0; w < KW / 32; w++) key[i][32*w +: 32] = $urandom();
        end
        jobs[0] = '{rv: 2'b01, inv: 2'b00, lat: 2, stall: 0, own: 1'b0};
        jobs[1] = '{rv: 2'b11, inv: 2'b10, lat: 3, stall: 5, own: 1'b1};
        jobs[2] = '{rv: 2'b11, inv: 2'b01, lat: 1, stall: 5, own: 1'b0};
        jobs[3] = '{rv: 2'b11, inv: 2'b00, lat: 4, stall: 1, own: 1'b1};
        jobs[4] = '{rv: 2'b11, inv: 2'b11, lat: 2, stall: 0, own: 1'b0};
        jobs[5] = '{rv: 2'b01, inv: 2'b00, lat: 1, stall: 2, own: 1'b0};
        jobs[6] = '{rv: 2'b10, inv: 2'b10, lat: 2, stall: 0, own: 1'b1};

        rst                = 1'b0;
        req_valid          = '0;
        req_inverse        = '0;
        req_sh_plaintext   = {pt[1], pt[0]};
        req_sh_key         = {key[1], key[0]};
        rsp_ready          = '0;
        core_in_ready      = 1'b0;
        core_cipher_valid  = 1'b0;
        core_sh_ciphertext = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", 512'(core_rst), 512'(1'b1));
        chk("rst_busy", 512'(busy), 512'(1'b1));
        chk("rst_ready", 512'(req_ready), 512'(0));
        chk("rst_rspv", 512'(rsp_valid), 512'(0));
        chk("rst_vin", 512'(core_valid_in), 512'(0));
        chk("rst_oready", 512'(core_out_ready), 512'(0));
        chk("rst_inv", 512'(core_inverse), 512'(0));
        chk("rst_key", 512'(core_sh_key), 512'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rel0_core_rst", 512'(core_rst), 512'(1'b1));
        step();
        @(negedge clk);
        chk("rel1_core_rst", 512'(core_rst), 512'(1'b1));
        chk("rel1_busy", 512'(busy), 512'(1'b1));
        step();
        @(negedge clk);
        chk("rel2_core_rst", 512'(core_rst), 512'(0));
        chk("rel2_busy", 512'(busy), 512'(0));
        step();

        foreach (jobs[i]) run_job(jobs[i]);

        // Core not ready: request must be held without a grant.
        req_valid     = 2'b11;
        core_in_ready = 1'b0;
        @(negedge clk);
        chk("hold_ready", 512'(req_ready), 512'(0));
        chk("hold_vin", 512'(core_valid_in), 512'(0));
        chk("hold_key", 512'(core_sh_key), 512'(0));
        step();
        @(negedge clk);
        chk("hold_busy", 512'(busy), 512'(0));
        step();
        req_valid = '0;

        // Reset while the job is in RUN: job silently dropped.
        req_valid     = 2'b10;
        core_in_ready = 1'b1;
        @(negedge clk);
        chk("abort_grant", 512'(req_ready), 512'(2'b10));
        step();
        req_valid          = '0;
        core_cipher_valid  = 1'b1;
        core_sh_ciphertext = '1;
        rst                = 1'b0;
        @(negedge clk);
        chk("abort_core_rst", 512'(core_rst), 512'(1'b1));
        chk("abort_rspv", 512'(rsp_valid), 512'(0));
        chk("abort_oready", 512'(core_out_ready), 512'(0));
        chk("abort_ct", 512'(rsp_sh_ciphertext), 512'(0));
        step();
        rst       = 1'b1;
        rsp_ready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", 512'(rsp_valid), 512'(0));
            step();
        end
        core_cipher_valid  = 1'b0;
        core_sh_ciphertext = '0;
        rsp_ready          = '0;
        run_job('{rv: 2'b11, inv: 2'b01, lat: 2, stall: 1, own: 1'b0});

`ifdef MSKAES_ARB_WATCHDOG_EN
        req_valid     = 2'b01;
        core_in_ready = 1'b1;
        @(negedge clk);
        chk("wd_grant", 512'(core_valid_in), 512'(1'b1));
        step();
        req_valid = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk("wd_run_rst", 512'(core_rst), 512'(0));
            step();
        end
        @(negedge clk);
        chk("wd_pulse", 512'(core_rst), 512'(1'b1));
        chk("wd_err_set", 512'(wd_err), 512'(1'b1));
        step();
        @(negedge clk);
        chk("wd_pulse_end", 512'(core_rst), 512'(0));
        chk("wd_idle", 512'(busy), 512'(0));
        chk("wd_err_sticky", 512'(wd_err), 512'(1'b1));
        step();
`endif

        chk("sb_drained", 512'(sb.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
